// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU op codes, divider states
// and the mem_ctrl field layout also used by MEM_stage.
package exe_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_SLT   = 5'd4;
  localparam logic [4:0] OP_SLTU  = 5'd5;
  localparam logic [4:0] OP_AND   = 5'd6;
  localparam logic [4:0] OP_OR    = 5'd7;
  localparam logic [4:0] OP_XOR   = 5'd8;
  localparam logic [4:0] OP_NOR   = 5'd9;
  localparam logic [4:0] OP_SLL   = 5'd10;
  localparam logic [4:0] OP_SRL   = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12;
  localparam logic [4:0] OP_LUI   = 5'd13;
  localparam logic [4:0] OP_MULT  = 5'd14;
  localparam logic [4:0] OP_MULTU = 5'd15;
  localparam logic [4:0] OP_DIV   = 5'd16;
  localparam logic [4:0] OP_DIVU  = 5'd17;
  localparam logic [4:0] OP_MFHI  = 5'd18;
  localparam logic [4:0] OP_MFLO  = 5'd19;
  localparam logic [4:0] OP_MTHI  = 5'd20;
  localparam logic [4:0] OP_MTLO  = 5'd21;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // mem_ctrl: [16:15] byte-lane address bits, [14:0] MEM control proper
  localparam int WB_CTRL_W   = 10;
  localparam int MEM_CTRL_W  = 17;
  localparam int MC_ADDR_LSB = 15;
  localparam int MC_FIELD_W  = 15;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per BUSY cycle, sign
// fix-up applied combinationally while in DONE.
module div_iter
  import exe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_e state, state_nx;
  logic [31:0] rem_r, quo_r, dsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic neg_q_r, neg_r_r;
  logic load, step;

  logic a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] shifted, diff;
  logic fits;

  assign a_neg = sign && a[31];
  assign b_neg = sign && b[31];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // diff stays below 2^32 whenever the divisor fits, so bit 32 is the borrow
  assign shifted = {rem_r, quo_r[31]};
  assign diff    = shifted - {1'b0, dsr_r};
  assign fits    = !diff[32];

  always_ff @(posedge clk) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_r == CNT_W'(DIV_CYCLES - 1)) state_nx = DIV_DONE;
      end
      DIV_DONE: begin
        done     = 1'b1;
        state_nx = DIV_IDLE;
      end
      default: state_nx = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_r   <= '0;
      quo_r   <= '0;
      dsr_r   <= '0;
      cnt_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (load) begin
      rem_r   <= '0;
      quo_r   <= mag_a;
      dsr_r   <= mag_b;
      cnt_r   <= '0;
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
    end else if (step) begin
      rem_r <= fits ? diff[31:0] : shifted[31:0];
      quo_r <= {quo_r[30:0], fits};
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign q = neg_q_r ? -quo_r : quo_r;
  assign r = neg_r_r ? -rem_r : rem_r;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ID/EXE register, ALU, HI/LO with single-cycle
// multiply and a stalling iterative divider.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           src_a_i,
  input  logic [31:0]           src_b_i,
  input  logic [31:0]           rd2_i,
  input  logic [4:0]            alu_op_i,
  input  logic [WB_CTRL_W-1:0]  wb_ctrl_i,
  input  logic [MEM_CTRL_W-1:0] mem_ctrl_i,
  input  logic [4:0]            db_dest_i,
  output logic                  stall_o,
  output logic [31:0]           pc_o,
  output logic [31:0]           inst_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           ALUOut_o,
  output logic [WB_CTRL_W-1:0]  wb_ctrl_o,
  output logic [MEM_CTRL_W-1:0] mem_ctrl_o,
  output logic [4:0]            db_dest_o
);

  logic [31:0] pc_r, inst_r, src_a_r, src_b_r, rd2_r;
  logic [4:0] op_r, dest_r;
  logic [WB_CTRL_W-1:0] wb_r;
  logic [MC_FIELD_W-1:0] mem_r;
  logic [31:0] hi_r, lo_r;
  logic [31:0] alu_out;
  logic [63:0] prod_s, prod_u;
  logic [4:0] sa;
  logic div_start, div_busy, div_done;
  logic [31:0] div_q, div_r;

  assign div_start = is_div_op(op_r) && !div_busy && !div_done;
  assign stall_o   = div_start || div_busy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r    <= '0;
      inst_r  <= '0;
      src_a_r <= '0;
      src_b_r <= '0;
      rd2_r   <= '0;
      op_r    <= '0;
      wb_r    <= '0;
      mem_r   <= '0;
      dest_r  <= '0;
    end else if (!stall_o) begin
      pc_r    <= pc_i;
      inst_r  <= inst_i;
      src_a_r <= src_a_i;
      src_b_r <= src_b_i;
      rd2_r   <= rd2_i;
      op_r    <= alu_op_i;
      wb_r    <= wb_ctrl_i;
      mem_r   <= mem_ctrl_i[MC_FIELD_W-1:0];
      dest_r  <= db_dest_i;
    end
  end

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .sign   (op_r == OP_DIV),
    .a      (src_a_r),
    .b      (src_b_r),
    .busy   (div_busy),
    .done   (div_done),
    .q      (div_q),
    .r      (div_r)
  );

  // Extending to 64 bits first keeps the low 64 bits of the product exact
  assign prod_s = {{32{src_a_r[31]}}, src_a_r} * {{32{src_b_r[31]}}, src_b_r};
  assign prod_u = {32'd0, src_a_r} * {32'd0, src_b_r};
  assign sa     = src_a_r[4:0];

  always_comb begin
    alu_out = '0;
    case (op_r)
      OP_ADD, OP_ADDU: alu_out = src_a_r + src_b_r;
      OP_SUB, OP_SUBU: alu_out = src_a_r - src_b_r;
      OP_SLT:          alu_out = {31'd0, $signed(src_a_r) < $signed(src_b_r)};
      OP_SLTU:         alu_out = {31'd0, src_a_r < src_b_r};
      OP_AND:          alu_out = src_a_r & src_b_r;
      OP_OR:           alu_out = src_a_r | src_b_r;
      OP_XOR:          alu_out = src_a_r ^ src_b_r;
      OP_NOR:          alu_out = ~(src_a_r | src_b_r);
      OP_SLL:          alu_out = src_b_r << sa;
      OP_SRL:          alu_out = src_b_r >> sa;
      OP_SRA:          alu_out = $unsigned($signed(src_b_r) >>> sa);
      OP_LUI:          alu_out = {src_b_r[15:0], 16'h0000};
      OP_MFHI:         alu_out = hi_r;
      OP_MFLO:         alu_out = lo_r;
      default:         alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (div_done) begin
      hi_r <= div_r;
      lo_r <= div_q;
    end else begin
      case (op_r)
        OP_MULT:  {hi_r, lo_r} <= prod_s;
        OP_MULTU: {hi_r, lo_r} <= prod_u;
        OP_MTHI:  hi_r <= src_a_r;
        OP_MTLO:  lo_r <= src_a_r;
        default: ;
      endcase
    end
  end

  // Bubble: MEM uses the strobes combinationally, so they must drop while held
  assign pc_o       = pc_r;
  assign inst_o     = inst_r;
  assign wdata_o    = rd2_r;
  assign db_dest_o  = dest_r;
  assign ALUOut_o   = alu_out;
  assign wb_ctrl_o  = stall_o ? '0 : wb_r;
  assign mem_ctrl_o = {alu_out[1:0], stall_o ? {MC_FIELD_W{1'b0}} : mem_r};

endmodule
